controller_sequencer: RTL and testbench

//  Microsequencer driving the 4-bit state input of the controller ROM.
//  - Holds the current control state.
//  - Steps through the fetch sequence, then dispatches on the decoded opcode.
//  - Stalls in memory-access states until mem_ready.
//  - Aborts to RES on a memory timeout.
//  - Counts retired instructions.

---
 rtl/controller_sequencer.sv | 139 +++++++++++++
 tb/tb_controller_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// Microsequencer producing the 4-bit control state for the controller ROM:
// fetch, opcode dispatch, memory wait states with timeout abort, retirement count.
module controller_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mem_ready,
    input  logic [1:0]       i_opcode,
    input  logic             i_br_cond,
    output logic [3:0]       o_state,
    output logic             o_busy,
    output logic             o_instr_done,
    output logic [CNT_W-1:0] o_instr_count,
    output logic             o_timeout_err
);

    // Encoding is fixed by the controller ROM contents.
    typedef enum logic [3:0] {
        StRes = 4'h0, StIf0 = 4'h1, StIf1 = 4'h2, StIf2 = 4'h3,
        StIf3 = 4'h4, StOd  = 4'h5, StLd0 = 4'h6, StLd1 = 4'h7,
        StLd2 = 4'h8, StSt0 = 4'h9, StSt1 = 4'hA, StAd0 = 4'hB,
        StAd1 = 4'hC, StAd2 = 4'hD, StBr0 = 4'hE, StBr1 = 4'hF
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_instr_done;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_timeout_err;
    logic             w_retire;
    logic             w_timeout;
    logic             w_is_wait;

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        w_is_wait   = 1'b0;
        case (r_state)
            StRes: if (i_start) w_state_nxt = StIf0;
            StIf0: w_state_nxt = StIf1;
            StIf1: begin
                w_is_wait = 1'b1;
                if (i_mem_ready) w_state_nxt = StIf2;
            end
            StIf2: w_state_nxt = StIf3;
            StIf3: w_state_nxt = StOd;
            StOd: begin
                case (i_opcode)
                    2'b00:   w_state_nxt = StLd0;
                    2'b01:   w_state_nxt = StSt0;
                    2'b10:   w_state_nxt = StAd0;
                    default: w_state_nxt = StBr0;
                endcase
            end
            StLd0: w_state_nxt = StLd1;
            StLd1: begin
                w_is_wait = 1'b1;
                if (i_mem_ready) w_state_nxt = StLd2;
            end
            StLd2: begin
                w_state_nxt = StIf0;
                w_retire    = 1'b1;
            end
            StSt0: w_state_nxt = StSt1;
            StSt1: begin
                w_is_wait = 1'b1;
                if (i_mem_ready) begin
                    w_state_nxt = StIf0;
                    w_retire    = 1'b1;
                end
            end
            StAd0: w_state_nxt = StAd1;
            StAd1: begin
                w_is_wait = 1'b1;
                if (i_mem_ready) w_state_nxt = StAd2;
            end
            StAd2: begin
                w_state_nxt = StIf0;
                w_retire    = 1'b1;
            end
            StBr0: begin
                if (i_br_cond) begin
                    w_state_nxt = StBr1;
                end else begin
                    w_state_nxt = StIf0;
                    w_retire    = 1'b1;
                end
            end
            StBr1: begin
                w_state_nxt = StIf0;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = StRes;
        endcase

        // mem_ready on the last allowed cycle still wins over the abort.
        if (w_is_wait && !i_mem_ready && (r_wait_cnt == WaitLast)) begin
            w_state_nxt = StRes;
            w_timeout   = 1'b1;
        end

        w_wait_cnt_nxt = (w_is_wait && !i_mem_ready) ? r_wait_cnt + 8'd1 : 8'd0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StRes;
            r_wait_cnt    <= 8'd0;
            r_instr_done  <= 1'b0;
            r_instr_count <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_instr_done <= w_retire;
            if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
            if (r_state == StRes && i_start) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_state       = r_state;
    assign o_busy        = (r_state != StRes);
    assign o_instr_done  = r_instr_done;
    assign o_instr_count = r_instr_count;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: vector table for the instruction paths,
// hand sequences for wait-state stalls, timeout abort, reset and counter wrap.
module tb_controller_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b1;
    logic [1:0]  opcode = 2'b00;
    logic        br_cond = 1'b0;

    logic [3:0]  state16, state4;
    logic        busy16, busy4, done16, done4, err16, err4;
    logic [15:0] count16;
    logic [3:0]  count4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    controller_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_ready(mem_ready),
        .i_opcode(opcode), .i_br_cond(br_cond), .o_state(state16), .o_busy(busy16),
        .o_instr_done(done16), .o_instr_count(count16), .o_timeout_err(err16)
    );

    controller_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mem_ready(mem_ready),
        .i_opcode(opcode), .i_br_cond(br_cond), .o_state(state4), .o_busy(busy4),
        .o_instr_done(done4), .o_instr_count(count4), .o_timeout_err(err4)
    );

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       mr;
        logic [1:0] op;
        logic       brc;
        logic [3:0] st;
        logic       done;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic m,
                                input logic [1:0] o, input logic b,
                                input logic [3:0] est, input logic edone, input int ecnt);
        vec_t v;
        v.rst_n = r; v.start = s; v.mr = m; v.op = o; v.brc = b;
        v.st = est; v.done = edone; v.cnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic m,
                        input logic [1:0] o, input logic b);
        rst_n = r; start = s; mem_ready = m; opcode = o; br_cond = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Common post-edge checks on both instances.
    task automatic chk_all(input string tag, input logic [3:0] est, input logic edone,
                           input int ecnt, input logic eerr);
        chk({tag, " state"}, 32'(state16), 32'(est));
        chk({tag, " state4"}, 32'(state4), 32'(est));
        chk({tag, " busy"}, 32'(busy16), 32'(est != 4'h0));
        chk({tag, " done"}, 32'(done16), 32'(edone));
        chk({tag, " count"}, 32'(count16), 32'(ecnt & 16'hFFFF));
        chk({tag, " count4"}, 32'(count4), 32'(ecnt & 4'hF));
        chk({tag, " err"}, 32'(err16), 32'(eerr));
    endtask

    initial begin
        // Test 1: LD path from reset.
        add(0, 0, 1, 2'd0, 0, 4'h0, 0, 0);
        add(1, 1, 1, 2'd0, 0, 4'h1, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h2, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h3, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h4, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h5, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h6, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h7, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h8, 0, 0);
        add(1, 0, 1, 2'd0, 0, 4'h1, 1, 1);
        // ST; opcode and start outside their sampling states are ignored.
        add(1, 0, 1, 2'd3, 0, 4'h2, 0, 1);
        add(1, 1, 1, 2'd3, 0, 4'h3, 0, 1);
        add(1, 0, 1, 2'd3, 0, 4'h4, 0, 1);
        add(1, 0, 1, 2'd3, 0, 4'h5, 0, 1);
        add(1, 0, 1, 2'd1, 0, 4'h9, 0, 1);
        add(1, 0, 1, 2'd0, 0, 4'hA, 0, 1);
        add(1, 0, 1, 2'd0, 0, 4'h1, 1, 2);
        // ADD.
        add(1, 0, 1, 2'd0, 0, 4'h2, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'h3, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'h4, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'h5, 0, 2);
        add(1, 0, 1, 2'd2, 0, 4'hB, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'hC, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'hD, 0, 2);
        add(1, 0, 1, 2'd0, 0, 4'h1, 1, 3);
        // BR taken.
        add(1, 0, 1, 2'd0, 0, 4'h2, 0, 3);
        add(1, 0, 1, 2'd0, 0, 4'h3, 0, 3);
        add(1, 0, 1, 2'd0, 0, 4'h4, 0, 3);
        add(1, 0, 1, 2'd0, 0, 4'h5, 0, 3);
        add(1, 0, 1, 2'd3, 0, 4'hE, 0, 3);
        add(1, 0, 1, 2'd0, 1, 4'hF, 0, 3);
        add(1, 0, 1, 2'd0, 0, 4'h1, 1, 4);
        // BR not taken; br_cond high during fetch must not matter.
        add(1, 0, 1, 2'd0, 1, 4'h2, 0, 4);
        add(1, 0, 1, 2'd0, 1, 4'h3, 0, 4);
        add(1, 0, 1, 2'd0, 1, 4'h4, 0, 4);
        add(1, 0, 1, 2'd0, 1, 4'h5, 0, 4);
        add(1, 0, 1, 2'd3, 1, 4'hE, 0, 4);
        add(1, 0, 1, 2'd0, 0, 4'h1, 1, 5);

        foreach (vecs[i]) begin
            tick(vecs[i].rst_n, vecs[i].start, vecs[i].mr, vecs[i].op, vecs[i].brc);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].cnt, 1'b0);
        end

        // Test 3: IF1 stall for 5 cycles.
        tick(1, 0, 1, 2'd0, 0);
        chk_all("if1 entry", 4'h2, 0, 5, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 2'd0, 0);
            chk_all($sformatf("if1 hold%0d", i), 4'h2, 0, 5, 0);
        end
        tick(1, 0, 1, 2'd0, 0);
        chk_all("if1 release", 4'h3, 0, 5, 0);

        // Test 4: LD1 timeout abort.
        tick(1, 0, 1, 2'd0, 0);
        tick(1, 0, 1, 2'd0, 0);
        tick(1, 0, 1, 2'd0, 0);
        tick(1, 0, 0, 2'd0, 0);
        chk_all("ld1 entry", 4'h7, 0, 5, 0);
        for (int i = 1; i < 15; i++) begin
            tick(1, 0, 0, 2'd0, 0);
            chk_all($sformatf("ld1 hold%0d", i), 4'h7, 0, 5, 0);
        end
        tick(1, 0, 0, 2'd0, 0);
        chk_all("ld1 timeout", 4'h0, 0, 5, 1);
        chk("timeout err4", 32'(err4), 32'd1);
        tick(1, 0, 1, 2'd0, 0);
        chk_all("res idle", 4'h0, 0, 5, 1);
        tick(1, 1, 1, 2'd0, 0);
        chk_all("restart", 4'h1, 0, 5, 0);

        // mem_ready on the last allowed stall cycle advances without error.
        tick(1, 0, 1, 2'd0, 0);
        for (int i = 0; i < 14; i++) tick(1, 0, 0, 2'd0, 0);
        chk_all("if1 hold14", 4'h2, 0, 5, 0);
        tick(1, 0, 1, 2'd0, 0);
        chk_all("if1 edge ready", 4'h3, 0, 5, 0);

        // Test 6: reset while in AD1; start ignored during reset.
        tick(1, 0, 1, 2'd0, 0);
        tick(1, 0, 1, 2'd0, 0);
        tick(1, 0, 1, 2'd2, 0);
        tick(1, 0, 0, 2'd0, 0);
        chk_all("ad1 entry", 4'hC, 0, 5, 0);
        tick(0, 1, 0, 2'd0, 0);
        chk_all("ad1 reset", 4'h0, 0, 0, 0);
        tick(1, 0, 1, 2'd0, 0);
        chk_all("post reset", 4'h0, 0, 0, 0);

        // Test 5: 17 branch-not-taken retirements, CNT_W=4 wraps.
        tick(1, 1, 1, 2'd0, 0);
        for (int k = 1; k <= 17; k++) begin
            tick(1, 0, 1, 2'd0, 0);
            tick(1, 0, 1, 2'd0, 0);
            tick(1, 0, 1, 2'd0, 0);
            tick(1, 0, 1, 2'd0, 0);
            tick(1, 0, 1, 2'd3, 0);
            chk_all($sformatf("wrap br0 %0d", k), 4'hE, 0, k - 1, 0);
            tick(1, 0, 1, 2'd0, 0);
            chk_all($sformatf("wrap ret %0d", k), 4'h1, 1, k, 0);
            chk($sformatf("wrap done4 %0d", k), 32'(done4), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
